// File: rtl/ldpc_llr_in.sv
// Channel LLR input buffer for an LDPC decoder: saturates raw LLRs and collects
// them into two ping-pong frame banks that the decoder reads by address.
module ldpc_llr_in #(
    parameter int IN_WID = 8,
    parameter int D_WID  = 6,
    parameter int N_LEN  = 64,
    parameter int AW     = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sync_in,
    input  logic                     valid_in,
    input  logic signed [IN_WID-1:0] data_in,
    input  logic                     code_rate,
    output logic                     in_ready,
    output logic                     frm_rdy,
    output logic                     frm_rate,
    input  logic                     rd_en,
    input  logic [AW-1:0]            rd_addr,
    output logic signed [D_WID-1:0]  rd_data,
    input  logic                     frm_done,
    output logic                     frm_err
);

    localparam int                      SAT_MAX   = (1 << (D_WID - 1)) - 1;
    localparam logic signed [IN_WID-1:0] SAT_HI    = IN_WID'(SAT_MAX);
    localparam logic signed [IN_WID-1:0] SAT_LO    = IN_WID'(-SAT_MAX);
    localparam logic signed [D_WID-1:0]  OUT_HI    = D_WID'(SAT_MAX);
    localparam logic signed [D_WID-1:0]  OUT_LO    = D_WID'(-SAT_MAX);
    localparam logic [AW-1:0]            LAST_ADDR = AW'(N_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    // Symmetric clip: the most negative code is never produced.
    function automatic logic signed [D_WID-1:0] f_sat(input logic signed [IN_WID-1:0] din);
        logic signed [D_WID-1:0] res;
        if (din > SAT_HI) begin
            res = OUT_HI;
        end else if (din < SAT_LO) begin
            res = OUT_LO;
        end else begin
            res = din[D_WID-1:0];
        end
        return res;
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_wr_bank;
    logic                    w_wr_bank_nxt;
    logic                    r_rd_bank;
    logic                    w_rd_bank_nxt;
    logic [1:0]              r_full;
    logic [1:0]              w_full_nxt;
    logic [1:0]              r_rate;
    logic [1:0]              w_rate_nxt;
    logic [AW-1:0]           r_wr_cnt;
    logic [AW-1:0]           w_wr_cnt_nxt;
    logic                    r_in_ready;
    logic                    r_frm_err;
    logic                    w_frm_err_nxt;
    logic                    w_acc;
    logic                    w_wr_en;
    logic [AW-1:0]           w_wr_addr;
    logic signed [D_WID-1:0] w_sat_p0;
    logic signed [D_WID-1:0] r_rd_data_p1;
    logic signed [D_WID-1:0] r_mem [0:1][0:N_LEN-1];

    assign w_acc    = valid_in & r_in_ready;
    assign w_sat_p0 = f_sat(data_in);

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_cnt_nxt  = r_wr_cnt;
        w_wr_bank_nxt = r_wr_bank;
        w_rd_bank_nxt = r_rd_bank;
        w_full_nxt    = r_full;
        w_rate_nxt    = r_rate;
        w_frm_err_nxt = 1'b0;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_wr_cnt;

        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (sync_in) begin
                        w_wr_en                = 1'b1;
                        w_wr_addr              = '0;
                        w_rate_nxt[r_wr_bank]  = code_rate;
                        w_wr_cnt_nxt           = AW'(1);
                        w_state_nxt            = S_FILL;
                    end
                end
                S_FILL: begin
                    if (sync_in) begin
                        // Truncated frame: restart the same bank with this sample.
                        w_frm_err_nxt          = 1'b1;
                        w_wr_en                = 1'b1;
                        w_wr_addr              = '0;
                        w_rate_nxt[r_wr_bank]  = code_rate;
                        w_wr_cnt_nxt           = AW'(1);
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_wr_cnt;
                        if (r_wr_cnt == LAST_ADDR) begin
                            w_full_nxt[r_wr_bank] = 1'b1;
                            w_wr_bank_nxt         = ~r_wr_bank;
                            w_wr_cnt_nxt          = '0;
                            w_state_nxt           = S_IDLE;
                        end else begin
                            w_wr_cnt_nxt = r_wr_cnt + AW'(1);
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // Release can never hit the bank being completed: that one is not full.
        if (frm_done && r_full[r_rd_bank]) begin
            w_full_nxt[r_rd_bank] = 1'b0;
            w_rd_bank_nxt         = ~r_rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_full     <= '0;
            r_rate     <= '0;
            r_in_ready <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_full     <= w_full_nxt;
            r_rate     <= w_rate_nxt;
            r_in_ready <= ~w_full_nxt[w_wr_bank_nxt];
            r_frm_err  <= w_frm_err_nxt;
        end
    end

    // ---- stage p0 -> storage ----
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_bank][w_wr_addr] <= w_sat_p0;
        end
    end

    // ---- storage -> stage p1 (registered read port) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data_p1 <= '0;
        end else if (rd_en) begin
            r_rd_data_p1 <= r_mem[r_rd_bank][rd_addr];
        end
    end

    assign in_ready = r_in_ready;
    assign frm_rdy  = r_full[r_rd_bank];
    assign frm_rate = r_rate[r_rd_bank];
    assign rd_data  = r_rd_data_p1;
    assign frm_err  = r_frm_err;

endmodule

// File: tb/tb_ldpc_llr_in.sv
// Randomized and directed bench for ldpc_llr_in against a frame-queue reference model.
module tb_ldpc_llr_in;

    localparam int IN_WID = 8;
    localparam int D_WID  = 6;
    localparam int N_LEN  = 64;
    localparam int AW     = 6;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     sync_in = 1'b0;
    logic                     valid_in = 1'b0;
    logic signed [IN_WID-1:0] data_in = '0;
    logic                     code_rate = 1'b0;
    logic                     rd_en = 1'b0;
    logic [AW-1:0]            rd_addr = '0;
    logic                     frm_done = 1'b0;
    logic                     in_ready;
    logic                     frm_rdy;
    logic                     frm_rate;
    logic signed [D_WID-1:0]  rd_data;
    logic                     frm_err;

    ldpc_llr_in #(
        .IN_WID(IN_WID),
        .D_WID (D_WID),
        .N_LEN (N_LEN),
        .AW    (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sync_in  (sync_in),
        .valid_in (valid_in),
        .data_in  (data_in),
        .code_rate(code_rate),
        .in_ready (in_ready),
        .frm_rdy  (frm_rdy),
        .frm_rate (frm_rate),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .frm_done (frm_done),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err_pulses = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_ref(input int v);
        int lim;
        lim = (1 << (D_WID - 1)) - 1;
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Reference: a FIFO of completed frames (capacity two) plus one frame being collected.
    typedef struct {
        bit rate;
        int d[N_LEN];
    } frame_t;

    frame_t m_fq[$];
    frame_t m_cur;
    bit     m_active = 1'b0;
    int     m_cnt = 0;
    bit     m_in_ready = 1'b0;
    bit     m_err = 1'b0;
    int     m_rd_exp = 0;
    bit     m_rd_known = 1'b0;

    always @(posedge clk) begin : model
        bit acc;
        bit done_ok;
        if (reset) begin
            m_fq.delete();
            m_active   = 1'b0;
            m_cnt      = 0;
            m_in_ready = 1'b0;
            m_err      = 1'b0;
            m_rd_exp   = 0;
            m_rd_known = 1'b1;
        end else begin
            acc     = valid_in && m_in_ready;
            done_ok = frm_done && (m_fq.size() > 0);
            if (rd_en) begin
                if (m_fq.size() > 0) begin
                    m_rd_exp   = m_fq[0].d[rd_addr];
                    m_rd_known = 1'b1;
                end else begin
                    m_rd_known = 1'b0;
                end
            end
            m_err = 1'b0;
            if (acc) begin
                if (sync_in) begin
                    m_err        = m_active;
                    m_cur.rate   = code_rate;
                    m_cur.d[0]   = sat_ref(int'(data_in));
                    m_cnt        = 1;
                    m_active     = 1'b1;
                end else if (m_active) begin
                    m_cur.d[m_cnt] = sat_ref(int'(data_in));
                    m_cnt++;
                    if (m_cnt == N_LEN) begin
                        m_fq.push_back(m_cur);
                        m_active = 1'b0;
                        m_cnt    = 0;
                    end
                end
            end
            if (done_ok) void'(m_fq.pop_front());
            m_in_ready = (m_fq.size() < 2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        check_val("in_ready", int'(in_ready), int'(m_in_ready));
        check_val("frm_rdy", int'(frm_rdy), int'(m_fq.size() > 0));
        check_val("frm_err", int'(frm_err), int'(m_err));
        if (frm_err) n_err_pulses++;
        if (m_fq.size() > 0) check_val("frm_rate", int'(frm_rate), int'(m_fq[0].rate));
        if (m_rd_known) check_val("rd_data", int'(rd_data), m_rd_exp);
    endtask

    task automatic drive(input bit v, input bit s, input bit r, input int d);
        valid_in  = v;
        sync_in   = s;
        code_rate = r;
        data_in   = IN_WID'(d);
    endtask

    task automatic send(input bit s, input bit r, input int d);
        bit acc;
        acc = 1'b0;
        drive(1'b1, s, r, d);
        for (int k = 0; k < 200 && !acc; k++) begin
            acc = m_in_ready;
            tick();
        end
        check_val("send_accept", int'(acc), 1);
    endtask

    task automatic send_frame(input bit r, input int d[N_LEN]);
        for (int i = 0; i < N_LEN; i++) send(i == 0, r, d[i]);
    endtask

    task automatic read_frame(input string tag, input int e[N_LEN]);
        for (int a = 0; a < N_LEN; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            tick();
            check_val(tag, int'(rd_data), e[a]);
        end
        rd_en = 1'b0;
    endtask

    task automatic pulse_done();
        frm_done = 1'b1;
        tick();
        frm_done = 1'b0;
    endtask

    task automatic rand_frame(output int d[N_LEN], output int e[N_LEN]);
        for (int i = 0; i < N_LEN; i++) begin
            d[i] = $urandom_range(255) - 128;
            e[i] = sat_ref(d[i]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  d[N_LEN];
        int  e[N_LEN];
        int  dB[N_LEN];
        int  eB[N_LEN];
        int  dC[N_LEN];
        int  eC[N_LEN];
        bit  rC;
        bit  rQ;

        // Reset and first cycle after release
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_val("post_rst_in_ready", int'(in_ready), 1);
        check_val("post_rst_frm_rate", int'(frm_rate), 0);
        check_val("post_rst_frm_rdy", int'(frm_rdy), 0);

        // Stray samples in IDLE and a release with nothing readable
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'(($urandom_range(1))), $urandom_range(255) - 128);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        pulse_done();
        tick();
        check_val("stray_frm_rdy", int'(frm_rdy), 0);

        // Ramp frame, rate 3/4
        for (int i = 0; i < N_LEN; i++) begin
            d[i] = i - 32;
            e[i] = (i - 32 < -31) ? -31 : i - 32;
        end
        send_frame(1'b1, d);
        drive(1'b0, 1'b0, 1'b0, 0);
        tick();
        check_val("ramp_frm_rdy", int'(frm_rdy), 1);
        check_val("ramp_frm_rate", int'(frm_rate), 1);
        read_frame("ramp_rd", e);
        pulse_done();

        // Saturation corners
        rand_frame(d, e);
        d[0] = 127;  e[0] = 31;
        d[1] = -128; e[1] = -31;
        d[2] = 31;   e[2] = 31;
        d[3] = -32;  e[3] = -31;
        d[4] = 0;    e[4] = 0;
        send_frame(1'b0, d);
        drive(1'b0, 1'b0, 1'b0, 0);
        tick();
        read_frame("sat_rd", e);
        pulse_done();

        // Back-pressure: three frames back to back, release withheld
        rand_frame(d, e);
        rand_frame(dB, eB);
        rand_frame(dC, eC);
        rC = 1'($urandom_range(1));
        send_frame(1'b0, d);
        send_frame(1'b1, dB);
        check_val("bp_in_ready_low", int'(in_ready), 0);
        drive(1'b1, 1'b1, rC, dC[0]);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_val("bp_stall", int'(in_ready), 0);
        end
        pulse_done();
        check_val("bp_rate_after_done", int'(frm_rate), 1);
        check_val("bp_in_ready_back", int'(in_ready), 1);
        send_frame(rC, dC);
        drive(1'b0, 1'b0, 1'b0, 0);
        tick();
        read_frame("bp_frame2", eB);
        pulse_done();
        check_val("bp_frame3_rate", int'(frm_rate), int'(rC));
        read_frame("bp_frame3", eC);
        pulse_done();

        // Completion on one bank and release of the other in the same cycle
        rand_frame(d, e);
        send_frame(1'b0, d);
        rand_frame(dB, eB);
        rQ = 1'($urandom_range(1));
        for (int i = 0; i < N_LEN - 1; i++) send(i == 0, rQ, dB[i]);
        drive(1'b1, 1'b0, rQ, dB[N_LEN-1]);
        check_val("same_cycle_ready", int'(in_ready), 1);
        frm_done = 1'b1;
        tick();
        frm_done = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);
        tick();
        check_val("same_cycle_rdy", int'(frm_rdy), 1);
        check_val("same_cycle_rate", int'(frm_rate), int'(rQ));
        read_frame("same_cycle_rd", eB);
        pulse_done();

        // Truncation: short frame cut by a new sync
        n_err_pulses = 0;
        for (int i = 0; i < 20; i++) send(i == 0, 1'b1, $urandom_range(255) - 128);
        rand_frame(d, e);
        send_frame(1'b0, d);
        drive(1'b0, 1'b0, 1'b0, 0);
        tick();
        tick();
        check_val("trunc_err_pulses", n_err_pulses, 1);
        check_val("trunc_frm_rate", int'(frm_rate), 0);
        read_frame("trunc_rd", e);
        pulse_done();

        // Reset in the middle of the second frame
        rand_frame(d, e);
        send_frame(1'b1, d);
        for (int i = 0; i < 40; i++) send(i == 0, 1'b0, $urandom_range(255) - 128);
        drive(1'b0, 1'b0, 1'b0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_val("midrst_frm_rdy", int'(frm_rdy), 0);
        check_val("midrst_in_ready", int'(in_ready), 1);
        rand_frame(d, e);
        send_frame(1'b0, d);
        drive(1'b0, 1'b0, 1'b0, 0);
        tick();
        read_frame("midrst_rd", e);
        pulse_done();

        // Randomized traffic, reads and releases
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(3) != 0),
                  m_active ? ($urandom_range(63) == 0) : ($urandom_range(2) == 0),
                  1'($urandom_range(1)),
                  $urandom_range(255) - 128);
            rd_en    = 1'($urandom_range(1));
            rd_addr  = AW'($urandom_range(N_LEN - 1));
            frm_done = ($urandom_range(23) == 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 0);
        rd_en    = 1'b0;
        frm_done = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ldpc_llr_in.md
LDPC_LLR_IN -- requirements
Module: ldpc_llr_in

Interface
- REQ-001: Parameters SHALL be, one per line:
  - IN_WID, 8, raw channel LLR width (signed).
  - D_WID, 6, decoder LLR width (signed).
  - N_LEN, 64, codeword length in samples.
  - AW, 6, address width; must satisfy 2^AW >= N_LEN.
- REQ-002: The block SHALL have one clock; reset is synchronous and active-high. The ports are:
  - clk  in  1  rising-edge clock.
  - reset  in  1  synchronous, active-high reset.
  - sync_in  in  1  marks the first sample of a frame; qualified by valid_in.
  - valid_in  in  1  data_in is valid this cycle.
  - data_in  in  IN_WID  raw signed LLR.
  - code_rate  in  1  0 = 1/2, 1 = 3/4; sampled with the sync sample.
  - in_ready  out  1  the block accepts a sample this cycle.
  - frm_rdy  out  1  a complete frame is readable by the decoder.
  - frm_rate  out  1  code_rate captured for the readable frame.
  - rd_en  in  1  read strobe from the decoder.
  - rd_addr  in  AW  read address, 0..N_LEN-1.
  - rd_data  out  D_WID  saturated LLR, valid one cycle after rd_en.
  - frm_done  in  1  decoder releases the readable frame (1-cycle pulse).
  - frm_err  out  1  1-cycle pulse: truncated frame discarded.

Function
- REQ-003: Storage SHALL be two banks (ping-pong) of N_LEN x D_WID, each with a full flag and a stored rate bit.
- REQ-004: A sample SHALL be accepted iff valid_in & in_ready.
- REQ-005: in_ready SHALL be 1 iff the current write bank's full flag is 0; it is registered and updates the cycle after a flag change.
- REQ-006: Saturation SHALL clip signed data_in to [-(2^(D_WID-1)-1), +(2^(D_WID-1)-1)] = [-31,+31] (symmetric; -32 never stored); in-range values pass unchanged.
- REQ-007: The write FSM SHALL have states IDLE and FILL.
- REQ-008: In IDLE, an accepted sample without sync_in SHALL be dropped.
- REQ-009: In IDLE, an accepted sample with sync_in SHALL be written to address 0, capture code_rate into the bank's rate bit, set wr_cnt=1, and move the FSM to FILL.
- REQ-010: In FILL, each accepted sample without sync_in SHALL be written at wr_cnt, and wr_cnt SHALL increment.
- REQ-011: When the accepted sample's wr_cnt equals N_LEN-1, the block SHALL set the bank full, toggle the write bank, and move to IDLE.
- REQ-012: In FILL, an accepted sample with sync_in SHALL pulse frm_err for 1 cycle, restart the same bank at address 0 with that sample (new rate captured), set wr_cnt=1, and stay in FILL.
- REQ-013: A frame that is N_LEN samples long and whose first sample has sync_in SHALL complete even if sync_in is asserted again on the following sample; that following sample starts the next frame.
- REQ-014: frm_rdy SHALL equal the read bank's full flag; frm_rate SHALL equal the read bank's rate bit.
- REQ-015: rd_data SHALL be registered: rd_en at cycle t returns bank[rd_bank][rd_addr] at t+1; rd_data holds its value when rd_en=0.
- REQ-016: rd_en while frm_rdy=0 SHALL return don't-care data and have no side effect.
- REQ-017: frm_done while frm_rdy=1 SHALL clear the read bank's full flag and toggle the read bank; frm_rdy drops the next cycle.
- REQ-018: frm_done while frm_rdy=0 SHALL be ignored.
- REQ-019: Frame completion on one bank and frm_done on the other bank in the same cycle SHALL both take effect.
- REQ-020: If frm_done frees the write bank in the same cycle in_ready would be computed, in_ready SHALL rise the following cycle.
- REQ-021: Frames SHALL be delivered in arrival order; no frame is overwritten while full.

Reset
- REQ-022: While reset=1 at a clock edge, the block SHALL clear both full flags, set write bank=read bank=0, set FSM=IDLE, wr_cnt=0, and outputs in_ready=0, frm_rdy=0, frm_rate=0, rd_data=0, frm_err=0.
- REQ-023: in_ready SHALL be 1 on the first cycle after reset deasserts.
- REQ-024: Reset mid-frame SHALL discard partial and complete frames; memory contents need not be cleared.

Verification
- REQ-025: Feed 64 samples (sync on the first, rate=1, data_in=i-32), never assert frm_done -> frm_rdy=1 and frm_rate=1 after the 64th; reading addresses 0..63 returns -31,-31,-30..+31 (i-32 clipped to [-31,+31]).
- REQ-026: Saturation: data_in=+127, -128, +31, -32, 0 -> stored values +31, -31, +31, -31, 0.
- REQ-027: Back-pressure: send 3 back-to-back frames with frm_done withheld -> in_ready=0 after frame 2 completes; frame 3 stalls; after frm_done, frame 1 is released, frm_rdy shows frame 2's rate, and frame 3 resumes and completes intact.
- REQ-028: Truncation: sync, 20 samples, then sync again plus 64 samples -> frm_err pulses exactly once; the readable frame is the 64-sample frame only.
- REQ-029: Stray/ignored inputs: 10 samples without sync in IDLE, plus frm_done with frm_rdy=0 -> nothing stored, no state change, frm_rdy stays 0.
- REQ-030: Reset at sample 40 of frame 2 while frame 1 is full -> frm_rdy=0 and in_ready=1 one cycle after reset; a fresh frame loads into bank 0 correctly.
